// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM for a shared-resource multicycle MIPS datapath
//
// Purpose: sequences FETCH/DECODE/execute states over one ALU, one register
// file and one unified memory port; stalls on mem_ready, counts retired
// instructions and traps (sticky) on illegal op/funct encodings.
//
// Ports:
//   clk, reset (async active-low)
//   op, funct          opcode / function fields from the instruction register
//   zero               ALU zero flag (branch decision)
//   mem_ready          memory access completes this cycle
//   mem_req, memwrite, iord, irwrite, pcen, pcsrc,
//   alusrca, alusrcb, alucontrol, regdst, memtoreg, regwrite
//                      datapath selects and enables
//   retired            one-cycle pulse when an instruction completes
//   instr_count        retired-instruction counter (wraps)
//   halted             sticky illegal-instruction trap
//   state              current state encoding
module multicycle_ctrl #(
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             op,
   input  logic [5:0]             funct,
   input  logic                   zero,
   input  logic                   mem_ready,
   output logic                   mem_req,
   output logic                   memwrite,
   output logic                   iord,
   output logic                   irwrite,
   output logic                   pcen,
   output logic [1:0]             pcsrc,
   output logic                   alusrca,
   output logic [1:0]             alusrcb,
   output logic [3:0]             alucontrol,
   output logic                   regdst,
   output logic                   memtoreg,
   output logic                   regwrite,
   output logic                   retired,
   output logic [COUNT_WIDTH-1:0] instr_count,
   output logic                   halted,
   output logic [3:0]             state
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_ADDIEX = 4'd9;
   localparam logic [3:0] S_ADDIWB = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;
   localparam logic [3:0] S_TRAP   = 4'd15;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;

   logic [3:0]             state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [3:0]             funct_alu;
   logic                   funct_legal;

   // R-type funct decode, shared by EXEC's ALU control and its legality check
   always_comb begin
      funct_alu   = ALU_ADD;
      funct_legal = 1'b1;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         6'b000000: funct_alu = ALU_SLL;
         6'b000010: funct_alu = ALU_SRL;
         default:   funct_legal = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; op/funct stay valid in the IR after FETCH, so later
   // states (MEMADR, EXEC) can re-decode them directly.
   always_comb begin
      state_d = S_TRAP;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = funct_legal ? S_ALUWB : S_TRAP;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         default:  state_d = S_TRAP;
      endcase
   end

   // Output logic. Enables are forced low while reset is held so that an
   // abandoned access (e.g. FETCH with mem_ready=1) updates nothing.
   always_comb begin
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      pcsrc      = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucontrol = ALU_AND;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      retired    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alusrcb    = 2'b01;
            alucontrol = ALU_ADD;
            irwrite    = mem_ready;
            pcen       = mem_ready;
         end
         S_DECODE: begin
            alusrcb    = 2'b11;
            alucontrol = ALU_ADD;
         end
         S_MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = ALU_ADD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            retired  = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            memwrite = 1'b1;
            iord     = 1'b1;
            retired  = mem_ready;
         end
         S_EXEC: begin
            alusrca    = 1'b1;
            alucontrol = funct_alu;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            retired  = 1'b1;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = 2'b01;
            pcen       = zero;
            retired    = 1'b1;
         end
         S_ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = ALU_ADD;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
            retired  = 1'b1;
         end
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcen    = 1'b1;
            retired = 1'b1;
         end
         default: begin
         end
      endcase
      if (!reset) begin
         mem_req  = 1'b0;
         memwrite = 1'b0;
         irwrite  = 1'b0;
         pcen     = 1'b0;
         regwrite = 1'b0;
         retired  = 1'b0;
      end
   end

   // Retired-instruction counter, wraps modulo 2^COUNT_WIDTH
   always_comb begin
      count_d = count_q;
      if (retired) begin
         count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign instr_count = count_q;
   assign halted      = (state_q == S_TRAP);
   assign state       = state_q;

endmodule
